// File: rtl/hexdisp_ctrl_pkg.sv
// Shared types and constants for the six-digit hex display controller.
package hexdisp_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned GLYPH_W    = 7;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;

  // Dark digit: all segments and dp off (active-low).
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_HOLD
  } state_e;

  // Active-low segment glyphs g..a for nibbles 0..F.
  localparam logic [GLYPH_W-1:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex2seg.sv
// Nibble to active-low seven-segment glyph (a..g, no dp).
module hex2seg
  import hexdisp_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0]   nib_i,
  output logic [GLYPH_W-1:0] seg_o_c
);

  assign seg_o_c = GLYPH_TABLE[nib_i];

endmodule

// File: rtl/hexdisp_ctrl.sv
// Six-digit hex display controller: shadow capture, leading-zero blanking,
// per-digit decimal points and a free-running blink overlay.
module hexdisp_ctrl
  import hexdisp_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 10000000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] dp,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic                  ready,
  output logic [SEG_W-1:0]      sthex0,
  output logic [SEG_W-1:0]      sthex1,
  output logic [SEG_W-1:0]      sthex2,
  output logic [SEG_W-1:0]      sthex3,
  output logic [SEG_W-1:0]      sthex4,
  output logic [SEG_W-1:0]      sthex5
);

  localparam int unsigned TERM_CNT = CLK_HZ / (2 * BLINK_HZ) - 1;
  localparam int unsigned PS_W     = $clog2(TERM_CNT) + 1;

  state_e                  state_q, state_d;
  logic                    ready_q;
  logic                    capture_c;

  logic [VALUE_W-1:0]      value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic                    lz_q;

  logic [PS_W-1:0]         ps_q, ps_d;
  logic                    phase_q, phase_d;

  logic [GLYPH_W-1:0]      glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    lz_run;
  logic [SEG_W-1:0]        decoded [NUM_DIGITS];
  logic [SEG_W-1:0]        pat_q   [NUM_DIGITS];
  logic [SEG_W-1:0]        pat_d   [NUM_DIGITS];
  logic [SEG_W-1:0]        sthex_q [NUM_DIGITS];
  logic [SEG_W-1:0]        sthex_d [NUM_DIGITS];

  assign capture_c = load & ready_q;

  // Per-digit glyph lookup from the shadow value.
  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_dec
    hex2seg u_hex2seg (
      .nib_i   (value_q[g*NIB_W +: NIB_W]),
      .seg_o_c (glyph[g])
    );
  end

  // Next-state logic: capture -> one decode cycle -> one hold cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (capture_c) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Blink prescaler: wraps at the half-period count and flips the phase.
  always_comb begin
    ps_d    = ps_q + PS_W'(1);
    phase_d = phase_q;
    if (ps_q == PS_W'(TERM_CNT)) begin
      ps_d    = '0;
      phase_d = ~phase_q;
    end
  end

  // Leading-zero run from the top digit down; digit 0 is never blanked.
  always_comb begin
    lz_blank = '0;
    lz_run   = lz_q;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      lz_run      = lz_run & (value_q[i*NIB_W +: NIB_W] == '0);
      lz_blank[i] = lz_run;
    end
  end

  // Pattern latched on the decode edge, blink overlay applied every cycle.
  always_comb begin
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      decoded[i] = {~dp_q[i], lz_blank[i] ? {GLYPH_W{1'b1}} : glyph[i]};
      pat_d[i]   = (state_q == ST_DECODE) ? decoded[i] : pat_q[i];
      sthex_d[i] = (!phase_d && mask_q[i]) ? SEG_BLANK : pat_d[i];
    end
  end

  // FSM state and handshake register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Shadow registers, prescaler and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      dp_q    <= '0;
      lz_q    <= 1'b0;
      mask_q  <= '0;
      ps_q    <= '0;
      phase_q <= 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        pat_q[i]   <= SEG_BLANK;
        sthex_q[i] <= SEG_BLANK;
      end
    end else begin
      if (capture_c) begin
        value_q <= value;
        dp_q    <= dp;
        lz_q    <= lz_en;
        mask_q  <= blink_mask;
      end
      ps_q    <= ps_d;
      phase_q <= phase_d;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        pat_q[i]   <= pat_d[i];
        sthex_q[i] <= sthex_d[i];
      end
    end
  end

  assign ready  = ready_q;
  assign sthex0 = sthex_q[0];
  assign sthex1 = sthex_q[1];
  assign sthex2 = sthex_q[2];
  assign sthex3 = sthex_q[3];
  assign sthex4 = sthex_q[4];
  assign sthex5 = sthex_q[5];

endmodule

// File: tb/tb_hexdisp_ctrl.sv
// Bench for hexdisp_ctrl: behavioural display model checked every cycle,
// plus directed literal expectations.
module tb_hexdisp_ctrl;

  localparam int unsigned CLK_HZ   = 40;
  localparam int unsigned BLINK_HZ = 2;
  localparam int unsigned HALF     = CLK_HZ / (2 * BLINK_HZ);

  localparam logic [7:0] GL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk;
  logic        rst;
  logic [23:0] value;
  logic [5:0]  dp;
  logic        load;
  logic        lz_en;
  logic [5:0]  blink_mask;
  logic        ready;
  logic [7:0]  sthex [6];

  hexdisp_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .lz_en      (lz_en),
    .blink_mask (blink_mask),
    .ready      (ready),
    .sthex0     (sthex[0]),
    .sthex1     (sthex[1]),
    .sthex2     (sthex[2]),
    .sthex3     (sthex[3]),
    .sthex4     (sthex[4]),
    .sthex5     (sthex[5])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Literal expectation handshake (written by stimulus, checked by compare).
  logic        lit_valid = 1'b0;
  string       lit_name;
  logic [47:0] lit_segs;
  logic [5:0]  lit_care;
  logic        lit_rdy;
  logic        lit_rdy_care;

  // ---------------- behavioural model ----------------
  int          k;
  int          busy;
  logic        model_live;
  logic        disp_valid;
  logic [23:0] sh_val, disp_val;
  logic [5:0]  sh_dp, disp_dp, sh_mask, old_mask;
  logic        sh_lz, disp_lz;
  logic [7:0]  exp_seg [6];
  logic        exp_ready;

  function automatic logic [7:0] digit_seg(input logic [23:0] v, input logic [5:0] d,
                                           input logic lz, input int i);
    logic [23:0] upper;
    logic [3:0]  nib;
    logic [7:0]  s;
    upper = v >> (4 * i);
    nib   = upper[3:0];
    if (lz && i > 0 && upper == 24'h0) s = 8'hFF;
    else                               s = GL[nib];
    if (d[i]) s[7] = 1'b0;
    return s;
  endfunction

  always @(posedge clk) begin
    model_live = 1'b1;
    if (rst) begin
      k = 0; busy = 0; disp_valid = 1'b0;
      sh_val = '0; sh_dp = '0; sh_lz = 1'b0; sh_mask = '0;
      for (int i = 0; i < 6; i++) exp_seg[i] = 8'hFF;
      exp_ready = 1'b1;
    end else begin
      old_mask = sh_mask;
      k++;
      if (busy == 2) begin
        disp_val = sh_val; disp_dp = sh_dp; disp_lz = sh_lz;
        disp_valid = 1'b1; busy = 1;
      end else if (busy == 1) begin
        busy = 0;
      end else if (load) begin
        sh_val = value; sh_dp = dp; sh_lz = lz_en; sh_mask = blink_mask;
        busy = 2;
      end
      exp_ready = (busy == 0);
      for (int i = 0; i < 6; i++) begin
        if (!disp_valid)                                exp_seg[i] = 8'hFF;
        else if (((k / HALF) % 2) == 1 && old_mask[i]) exp_seg[i] = 8'hFF;
        else exp_seg[i] = digit_seg(disp_val, disp_dp, disp_lz, i);
      end
    end
  end

  // ---------------- single compare process ----------------
  always @(negedge clk) begin
    if (model_live === 1'b1) begin
      n_vec++;
      if ({sthex[5], sthex[4], sthex[3], sthex[2], sthex[1], sthex[0], ready} !==
          {exp_seg[5], exp_seg[4], exp_seg[3], exp_seg[2], exp_seg[1], exp_seg[0], exp_ready}) begin
        n_err++;
        $display("FAIL model k=%0d: got %h %h %h %h %h %h rdy=%b expected %h %h %h %h %h %h rdy=%b",
                 k, sthex[5], sthex[4], sthex[3], sthex[2], sthex[1], sthex[0], ready,
                 exp_seg[5], exp_seg[4], exp_seg[3], exp_seg[2], exp_seg[1], exp_seg[0], exp_ready);
      end
    end
    if (lit_valid) begin
      n_vec++;
      for (int i = 0; i < 6; i++) begin
        if (lit_care[i] && sthex[i] !== lit_segs[i*8 +: 8]) begin
          n_err++;
          $display("FAIL %s: sthex%0d got %h expected %h", lit_name, i, sthex[i], lit_segs[i*8 +: 8]);
        end
      end
      if (lit_rdy_care && ready !== lit_rdy) begin
        n_err++;
        $display("FAIL %s: ready got %b expected %b", lit_name, ready, lit_rdy);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit_check(input string nm, input logic [47:0] segs, input logic [5:0] care,
                           input logic rdy, input logic rdy_care);
    lit_name = nm; lit_segs = segs; lit_care = care;
    lit_rdy = rdy; lit_rdy_care = rdy_care;
    lit_valid = 1'b1;
    @(negedge clk);
    #1 lit_valid = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] v, input logic [5:0] d, input logic lz,
                         input logic [5:0] m);
    value = v; dp = d; lz_en = lz; blink_mask = m; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  localparam logic [47:0] ALL_FF = {6{8'hFF}};

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp = '0; lz_en = 1'b0; blink_mask = '0;
    cyc(3);
    lit_check("reset", ALL_FF, 6'h3F, 1'b1, 1'b1);
    rst = 1'b0;

    // Basic load and handshake timing.
    do_load(24'h012345, 6'h00, 1'b0, 6'h00);
    lit_check("basic_t1", ALL_FF, 6'h3F, 1'b0, 1'b1);
    cyc(1);
    lit_check("basic_t2", {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}, 6'h3F, 1'b0, 1'b1);
    cyc(1);
    lit_check("basic_t3", 48'h0, 6'h00, 1'b1, 1'b1);

    // Leading-zero blanking with a decimal point on digit 0.
    do_load(24'h000070, 6'b000001, 1'b1, 6'h00);
    cyc(1);
    lit_check("lz", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'h40}, 6'h3F, 1'b0, 1'b1);

    // Load during HOLD is dropped, not queued.
    do_load(24'hFFFFFF, 6'h3F, 1'b0, 6'h3F);
    lit_check("busy_drop", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'h40}, 6'h3F, 1'b1, 1'b1);
    cyc(3);
    lit_check("busy_noqueue", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'h40}, 6'h3F, 1'b1, 1'b1);

    // All-zero value with blanking keeps digit 0.
    do_load(24'h000000, 6'h00, 1'b1, 6'h00);
    cyc(1);
    lit_check("zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, 6'h3F, 1'b0, 1'b1);
    cyc(1);

    // Reset during DECODE aborts the update; next load works.
    do_load(24'hABCDEF, 6'h00, 1'b0, 6'h00);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    lit_check("rst_decode", ALL_FF, 6'h3F, 1'b1, 1'b1);
    cyc(2);
    lit_check("rst_dark", ALL_FF, 6'h3F, 1'b1, 1'b1);
    do_load(24'h012345, 6'h00, 1'b0, 6'h00);
    cyc(1);
    lit_check("after_rst", {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}, 6'h3F, 1'b0, 1'b1);
    cyc(1);

    // Reset and load together: reset wins.
    value = 24'h111111; load = 1'b1; rst = 1'b1;
    cyc(1);
    rst = 1'b0; load = 1'b0;
    cyc(1);
    lit_check("rst_load", ALL_FF, 6'h3F, 1'b1, 1'b1);

    // Blink on digit 0, phase preserved across a reload.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    do_load(24'h000008, 6'h00, 1'b0, 6'b000001);
    cyc(1);
    lit_check("blink_k2", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h80}, 6'h3F, 1'b0, 1'b1);
    cyc(8);
    lit_check("blink_k10", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF}, 6'h3F, 1'b1, 1'b1);
    cyc(9);
    lit_check("blink_k19", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF}, 6'h03, 1'b1, 1'b0);
    cyc(1);
    lit_check("blink_k20", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h80}, 6'h03, 1'b1, 1'b0);
    do_load(24'h000003, 6'h00, 1'b0, 6'b000001);
    cyc(1);
    lit_check("blink_k22", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hB0}, 6'h3F, 1'b0, 1'b1);
    cyc(8);
    lit_check("blink_k30", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF}, 6'h03, 1'b1, 1'b0);
    cyc(10);
    lit_check("blink_k40", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hB0}, 6'h03, 1'b1, 1'b0);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hexdisp_ctrl.md
HEXDISP_CTRL -- requirements
Module: hexdisp_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 10000000: system clock frequency in Hz.
REQ-002 The block SHALL have parameter BLINK_HZ, default 2: full blink frequency in Hz. The half-period terminal count is CLK_HZ/(2*BLINK_HZ)-1, which is 2499999 at the defaults.
REQ-003 Port clk, input, 1 bit: the single system clock. All logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1 bit: reset. It SHALL be synchronous and active-high.
REQ-005 Port value, input, 24 bits: six hex nibbles. Nibble 0 (bits 3:0) drives digit 0.
REQ-006 Port dp, input, 6 bits: per-digit decimal-point request; 1 = lit.
REQ-007 Port load, input, 1 bit: request to capture value/dp/lz_en/blink_mask.
REQ-008 Port lz_en, input, 1 bit: leading-zero blanking enable.
REQ-009 Port blink_mask, input, 6 bits: per-digit blink enable.
REQ-010 Port ready, output, 1 bit: the block accepts load this cycle.
REQ-011 Ports sthex0..sthex5, output, 8 bits each: active-low segment drives, bit0=a .. bit6=g, bit7=dp.

Function
REQ-012 A capture SHALL occur on any cycle where load=1 and ready=1. All four inputs SHALL be registered into shadow registers in that cycle.
REQ-013 The FSM SHALL have states IDLE, DECODE and HOLD.
- IDLE: ready=1. A capture moves the FSM to DECODE.
- DECODE: ready=0. The FSM moves to HOLD after exactly 1 cycle.
- HOLD: ready=0. The FSM returns to IDLE after 1 cycle.
REQ-014 sthex outputs SHALL reflect a captured value 2 cycles after the capture edge: the capture edge, then the DECODE register edge. Outputs SHALL be registered.
REQ-015 Load asserted while ready=0 SHALL be ignored. No capture SHALL occur and no queuing SHALL occur.
REQ-016 Hex decode SHALL use standard active-low glyphs for 0-F, for example 0 -> 8'hC0, 8 -> 8'h80, F -> 8'h8E with dp off.
REQ-017 Leading-zero blanking applies when lz_en=1. Digits 5 down to 1 SHALL be blanked (segments a-g = 1) while the digit and all higher digits are 0. Digit 0 SHALL never be blanked by this rule.
REQ-018 The dp bit SHALL be driven low when dp[i]=1, regardless of leading-zero blanking.
REQ-019 A free-running prescaler SHALL count 0 to the terminal count and then wrap to 0. Each wrap SHALL toggle the blink phase register.
REQ-020 When blink phase=0 and blink_mask[i]=1, sthex[i] SHALL be 8'hFF, including the dp bit. Otherwise the decoded pattern SHALL be shown.
REQ-021 The blink phase SHALL NOT be restarted by load, so blinking digits stay phase-aligned across updates.
REQ-022 Shadow registers SHALL retain their values indefinitely between loads.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL take these values:
- FSM = IDLE, ready = 1.
- prescaler = 0, blink phase = 1 (visible).
- shadow value = 0, dp = 0, lz_en = 0, blink_mask = 0.
- all sthex = 8'hFF (dark).
REQ-024 Reset asserted mid-operation (DECODE/HOLD) SHALL abort the pending update. The first cycle after reset SHALL show ready=1.
REQ-025 If rst and load are both 1 in the same cycle, reset SHALL take priority and no capture SHALL occur.

Structure
REQ-026 A shared package SHALL hold:
- the FSM state typedef;
- the 16-entry active-low glyph constant table;
- the blank constant 8'hFF.
REQ-027 A combinational sub-module hex2seg SHALL convert a 4-bit nibble to a 7-bit active-low glyph. hexdisp_ctrl SHALL instantiate it six times.
REQ-028 The prescaler width SHALL be $clog2 of the terminal count plus 1. No other hard-coded widths SHALL be used.

Verification
REQ-029 Reset: assert rst for 3 cycles -> all sthex = 8'hFF, ready = 1.
REQ-030 Basic load: load value=24'h012345, lz_en=0 at cycle t -> at t+2:
- sthex5 = C0, sthex4 = F9, sthex3 = A4, sthex2 = B0, sthex1 = 99, sthex0 = 92;
- ready = 0 at t+1 and t+2, ready = 1 at t+3.
REQ-031 Leading-zero blanking: load value=24'h000070, lz_en=1, dp=6'b000001 -> sthex5..2 = FF, sthex1 = F8, sthex0 = 40.
REQ-032 All-zero value: load value=0, lz_en=1 -> sthex5..1 = FF, sthex0 = C0.
REQ-033 Blink: with CLK_HZ=40 and BLINK_HZ=2 (terminal count 9), set blink_mask=6'b000001 -> sthex0 alternates between its glyph and FF every 10 cycles; other digits are steady.
REQ-034 Busy and reset handling:
- load pulsed during HOLD -> ignored, display unchanged;
- rst during DECODE -> outputs FF, next load is accepted normally.
